// File: rtl/serdes_rr_sched_if.sv
// rtl/serdes_rr_sched_if.sv - request, engine and response handshakes of the round-robin scheduler
interface serdes_rr_sched_if #(
  parameter int NREQ   = 4,
  parameter int LANE_W = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;

  logic              eng_start;
  logic [7:0]        eng_data;
  logic [LANE_W-1:0] eng_lane;
  logic              eng_done;
  logic [7:0]        eng_result;

  logic              rsp_valid;
  logic [LANE_W-1:0] rsp_lane;
  logic [7:0]        rsp_data;
  logic              rsp_ready;

  modport master (
    input  req_valid, req_data,
    output req_ready,
    output eng_start, eng_data, eng_lane,
    input  eng_done, eng_result,
    output rsp_valid, rsp_lane, rsp_data,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_data,
    input  req_ready,
    input  eng_start, eng_data, eng_lane,
    output eng_done, eng_result,
    input  rsp_valid, rsp_lane, rsp_data,
    output rsp_ready
  );
endinterface

// File: rtl/serdes_rr_sched.sv
// rtl/serdes_rr_sched.sv - round-robin scheduler sharing one byte engine among NREQ lanes
module serdes_rr_sched #(
  parameter int NREQ    = 4,
  parameter int LANE_W  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  serdes_rr_sched_if.master   bus,
  output logic                timeout_err,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [LANE_W-1:0] last_grant_q, last_grant_d;
  logic [7:0]        timer_q, timer_d;
  logic              eng_start_q, eng_start_d;
  logic [7:0]        eng_data_q, eng_data_d;
  logic [LANE_W-1:0] eng_lane_q, eng_lane_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [LANE_W-1:0] rsp_lane_q, rsp_lane_d;
  logic [7:0]        rsp_data_q, rsp_data_d;
  logic              timeout_err_q, timeout_err_d;

  logic              grant_found;
  logic [LANE_W-1:0] grant_lane;
  logic [LANE_W-1:0] scan_idx;
  logic [NREQ-1:0]   grant_oh;
  logic [7:0]        grant_data;
  logic              accept;

  // Scan upward from the lane after the last grant, wrapping, and take the first valid one.
  always_comb begin
    grant_found = 1'b0;
    grant_lane  = '0;
    scan_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = LANE_W'((int'(last_grant_q) + k) % NREQ);
      if (!grant_found && bus.req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_lane  = scan_idx;
      end
    end
    grant_oh   = grant_found ? (NREQ'(1) << grant_lane) : '0;
    grant_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_lane == LANE_W'(i)) begin
        grant_data = bus.req_data[i*8 +: 8];
      end
    end
  end

  assign accept        = (state_q == IDLE) && ena && grant_found;
  assign bus.req_ready = (rst_n && accept) ? grant_oh : '0;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    timer_d       = timer_q;
    eng_start_d   = 1'b0;
    eng_data_d    = eng_data_q;
    eng_lane_d    = eng_lane_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_lane_d    = rsp_lane_q;
    rsp_data_d    = rsp_data_q;
    timeout_err_d = 1'b0;
    if (!ena) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            eng_data_d   = grant_data;
            eng_lane_d   = grant_lane;
            last_grant_d = grant_lane;
            eng_start_d  = 1'b1;
            state_d      = ISSUE;
          end
        end
        ISSUE: begin
          timer_d = '0;
          state_d = WAIT;
        end
        WAIT: begin
          timer_d = timer_q + 8'd1;
          // A done arriving on the last allowed cycle still counts as success.
          if (bus.eng_done) begin
            rsp_data_d  = bus.eng_result;
            rsp_lane_d  = eng_lane_q;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else if (timer_q == TIMEOUT_M1) begin
            timeout_err_d = 1'b1;
            state_d       = IDLE;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= LANE_W'(NREQ - 1);
      timer_q       <= '0;
      eng_start_q   <= 1'b0;
      eng_data_q    <= '0;
      eng_lane_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_lane_q    <= '0;
      rsp_data_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      timer_q       <= timer_d;
      eng_start_q   <= eng_start_d;
      eng_data_q    <= eng_data_d;
      eng_lane_q    <= eng_lane_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_lane_q    <= rsp_lane_d;
      rsp_data_q    <= rsp_data_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.eng_start = eng_start_q;
  assign bus.eng_data  = eng_data_q;
  assign bus.eng_lane  = eng_lane_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_lane  = rsp_lane_q;
  assign bus.rsp_data  = rsp_data_q;
  assign timeout_err   = timeout_err_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_serdes_rr_sched.sv
// tb/tb_serdes_rr_sched.sv - randomized transaction-level bench for serdes_rr_sched
module tb_serdes_rr_sched;
  localparam int NREQ    = 4;
  localparam int LANE_W  = 2;
  localparam int TIMEOUT = 64;

  logic clk;
  logic rst_n;
  logic ena;
  logic timeout_err;
  logic busy;

  serdes_rr_sched_if #(.NREQ(NREQ), .LANE_W(LANE_W)) bus ();

  serdes_rr_sched #(.NREQ(NREQ), .LANE_W(LANE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .bus         (bus),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_total;
  int         n_bad;
  int         model_last;
  logic [7:0] lane_data [NREQ];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference arbitration: first valid lane strictly after the previous grant, wrapping.
  function automatic int model_pick(input logic [NREQ-1:0] m);
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (model_last + k) % NREQ;
      if (m[c]) return c;
    end
    return 0;
  endfunction

  task automatic drive_lanes(input logic [NREQ-1:0] m);
    bus.req_valid = m;
    for (int i = 0; i < NREQ; i++) bus.req_data[i*8 +: 8] = lane_data[i];
  endtask

  task automatic randomize_data();
    for (int i = 0; i < NREQ; i++) lane_data[i] = 8'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ena   = 1'b1;
    drive_lanes('1);
    bus.eng_done = 1'b0;
    bus.rsp_ready = 1'b0;
    #1;
    check_eq("reset_outs", {bus.eng_start, bus.rsp_valid, busy, timeout_err}, 4'b0000);
    check_eq("reset_ready", bus.req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = '0;
    model_last = NREQ - 1;
  endtask

  task automatic grant_issue(input logic [NREQ-1:0] m, output int lane);
    @(negedge clk);
    drive_lanes(m);
    bus.eng_done = 1'b0;
    bus.rsp_ready = 1'b0;
    #1;
    lane = model_pick(m);
    check_eq("grant_ready", bus.req_ready, 32'(1) << lane);
    check_eq("grant_busy", busy, 0);
    model_last = lane;
    @(negedge clk);
    bus.req_valid = NREQ'($urandom);
    #1;
    check_eq("issue_start", {bus.eng_start, busy, timeout_err, bus.rsp_valid}, 4'b1100);
    check_eq("issue_data", bus.eng_data, lane_data[lane]);
    check_eq("issue_lane", bus.eng_lane, lane);
    check_eq("issue_ready", bus.req_ready, 0);
  endtask

  task automatic wait_cycle(input int lane);
    @(negedge clk);
    bus.req_valid = NREQ'($urandom);
    #1;
    check_eq("wait_quiet", {timeout_err, bus.rsp_valid, bus.eng_start, busy}, 4'b0001);
    check_eq("wait_stable", {bus.eng_lane, bus.eng_data}, {LANE_W'(lane), lane_data[lane]});
    check_eq("wait_ready", bus.req_ready, 0);
  endtask

  // One full transaction; lat = cycles from eng_start to done, hold = extra rsp_ready-low cycles.
  task automatic do_txn(input logic [NREQ-1:0] m, input int lat, input int hold,
                        input bit hang, input bit echo, input logic [7:0] res_in);
    int lane;
    logic [7:0] res;
    grant_issue(m, lane);
    res = echo ? lane_data[lane] : res_in;
    if (hang) begin
      for (int c = 0; c < TIMEOUT; c++) wait_cycle(lane);
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      check_eq("timeout_pulse", {timeout_err, busy, bus.rsp_valid}, 3'b100);
      @(negedge clk);
      #1;
      check_eq("timeout_once", {timeout_err, busy, bus.rsp_valid}, 3'b000);
    end else begin
      for (int c = 1; c < lat; c++) wait_cycle(lane);
      @(negedge clk);
      bus.req_valid  = NREQ'($urandom);
      bus.eng_done   = 1'b1;
      bus.eng_result = res;
      #1;
      check_eq("done_cycle", {timeout_err, bus.rsp_valid, busy}, 3'b001);
      @(negedge clk);
      bus.eng_done  = 1'b0;
      bus.rsp_ready = (hold == 0);
      #1;
      check_eq("rsp_flags", {bus.rsp_valid, timeout_err, busy}, 3'b101);
      check_eq("rsp_lane", bus.rsp_lane, lane);
      check_eq("rsp_data", bus.rsp_data, res);
      for (int h = 1; h <= hold; h++) begin
        @(negedge clk);
        bus.rsp_ready  = (h == hold);
        bus.eng_done   = 1'($urandom);
        bus.eng_result = 8'($urandom);
        bus.req_valid  = NREQ'($urandom) | NREQ'(1);
        #1;
        check_eq("rsp_hold", {bus.rsp_valid, bus.rsp_lane, bus.rsp_data}, {1'b1, LANE_W'(lane), res});
        check_eq("rsp_hold_ready", bus.req_ready, 0);
      end
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      bus.eng_done  = 1'b0;
      bus.req_valid = '0;
      #1;
      check_eq("rsp_release", {bus.rsp_valid, busy}, 2'b00);
    end
  endtask

  task automatic do_abort(input logic [NREQ-1:0] m);
    int lane;
    grant_issue(m, lane);
    wait_cycle(lane);
    @(negedge clk);
    ena = 1'b0;
    bus.req_valid = m;
    #1;
    check_eq("abort_ready", bus.req_ready, 0);
    @(negedge clk);
    bus.eng_done   = 1'b1;
    bus.eng_result = 8'($urandom);
    #1;
    check_eq("abort_idle", {busy, bus.rsp_valid, bus.eng_start, timeout_err}, 4'b0000);
    check_eq("abort_no_ready", bus.req_ready, 0);
    @(negedge clk);
    bus.eng_done  = 1'b0;
    bus.req_valid = '0;
    ena = 1'b1;
    #1;
    check_eq("abort_no_rsp", {busy, bus.rsp_valid}, 2'b00);
  endtask

  task automatic idle_spurious();
    @(negedge clk);
    bus.req_valid  = '0;
    bus.eng_done   = 1'b1;
    bus.eng_result = 8'($urandom);
    #1;
    check_eq("spur_busy", busy, 0);
    @(negedge clk);
    bus.eng_done = 1'b0;
    #1;
    check_eq("spur_quiet", {busy, bus.rsp_valid, bus.eng_start, timeout_err}, 4'b0000);
  endtask

  task automatic mid_reset(input logic [NREQ-1:0] m);
    int lane;
    grant_issue(m, lane);
    wait_cycle(lane);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_outs", {busy, bus.rsp_valid, bus.eng_start, timeout_err}, 4'b0000);
    check_eq("midrst_ready", bus.req_ready, 0);
    @(negedge clk);
    bus.req_valid = '0;
    rst_n = 1'b1;
    model_last = NREQ - 1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    model_last = NREQ - 1;
    rst_n = 1'b0;
    ena   = 1'b1;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.eng_done   = 1'b0;
    bus.eng_result = '0;
    bus.rsp_ready  = 1'b0;
    randomize_data();
    do_reset();

    lane_data[2] = 8'h3C;
    do_txn(4'b0100, 3, 0, 1'b0, 1'b0, 8'h99);

    do_reset();
    for (int i = 0; i < NREQ; i++) lane_data[i] = 8'h10 + 8'(i);
    for (int t = 0; t < 5; t++) do_txn(4'hF, 2, 0, 1'b0, 1'b1, 8'h00);

    do_txn(4'hF, 0, 0, 1'b1, 1'b0, 8'h00);
    do_txn(4'hF, 2, 0, 1'b0, 1'b1, 8'h00);

    do_txn(4'hF, 2, 10, 1'b0, 1'b0, 8'h5A);

    do_abort(4'hF);
    do_txn(4'hF, 1, 0, 1'b0, 1'b0, 8'hA7);

    do_txn(4'hF, TIMEOUT, 0, 1'b0, 1'b0, 8'hC3);
    idle_spurious();
    do_txn(4'hF, 1, 1, 1'b0, 1'b1, 8'h00);

    mid_reset(4'hF);
    do_txn(4'hF, 1, 0, 1'b0, 1'b1, 8'h00);

    for (int n = 0; n < 60; n++) begin
      int r;
      logic [NREQ-1:0] m;
      randomize_data();
      r = $urandom_range(0, 15);
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      if (r == 0) do_txn(m, 0, 0, 1'b1, 1'b0, 8'h00);
      else if (r == 1) do_abort(m);
      else if (r == 2) idle_spurious();
      else do_txn(m, $urandom_range(1, 6), $urandom_range(0, 3), 1'b0, 1'b0, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "bench time limit expired");
  end
endmodule
